// File: rtl/ecpri_pkt_writer.sv
// eCPRI ingress writer: streams frame bytes into RAM port 0,
// validates length/EtherType, hands good frames to ecpri_rx.
module ecpri_pkt_writer #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 16,
  parameter int          MIN_PKT_LEN = 18,
  parameter int          MAX_PKT_LEN = 1500,
  parameter logic [15:0] ETH_TYPE    = 16'hAEFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] addr_0,
  output logic [DATA_WIDTH-1:0] data_0,
  output logic                  cs_0,
  output logic                  we_0,
  output logic                  oe_0,
  output logic                  pkt_ready,
  output logic [ADDR_WIDTH-1:0] pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] MIN_L = ADDR_WIDTH'(MIN_PKT_LEN);
  localparam logic [ADDR_WIDTH-1:0] MAX_L = ADDR_WIDTH'(MAX_PKT_LEN);
  localparam logic [ADDR_WIDTH-1:0] OFS_H = ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] OFS_L = ADDR_WIDTH'(13);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] count, count_n;
  logic                  hi_ok, hi_n;
  logic                  type_ok, tok_n;
  logic                  rdy_q;
  logic                  accept;
  logic                  start;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] len_n;
  logic                  prdy_n;
  logic [1:0]            drops;
  logic [16:0]           drop_sum;

  assign in_ready = rdy_q && (state != S_HOLD);
  assign accept   = in_valid && in_ready;
  assign oe_0     = 1'b0;
  assign drop_sum = {1'b0, drop_cnt} + 17'(drops);

  always_comb begin
    state_n = state;
    count_n = count;
    hi_n    = hi_ok;
    tok_n   = type_ok;
    start   = 1'b0;
    wr      = 1'b0;
    waddr   = count;
    len_n   = pkt_len;
    prdy_n  = 1'b0;
    drops   = 2'd0;
    unique case (state)
      S_IDLE, S_DROP: begin
        if (accept) begin
          if (in_sop) begin
            start = 1'b1;
            if (state == S_DROP) drops = 2'd1;
          end else if (state == S_DROP && in_eop) begin
            drops   = 2'd1;
            state_n = S_IDLE;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          if (in_sop) begin
            start = 1'b1;
            drops = 2'd1;
          end else if (count == MAX_L) begin
            // buffer full: the overflow byte is never written
            state_n = in_eop ? S_IDLE : S_DROP;
            drops   = in_eop ? 2'd1 : 2'd0;
          end else begin
            wr      = 1'b1;
            waddr   = count;
            count_n = count + ONE;
            if (count == OFS_H) hi_n = (in_data == ETH_TYPE[15:8]);
            if (count == OFS_L) tok_n = hi_ok && (in_data == ETH_TYPE[7:0]);
            if (in_eop) begin
              if (count_n >= MIN_L && type_ok) begin
                state_n = S_HOLD;
                len_n   = count_n;
              end else begin
                state_n = S_IDLE;
                drops   = 2'd1;
              end
            end
          end
        end
      end
      S_HOLD: begin
        prdy_n = 1'b1;
        if (pkt_ready && pkt_done) begin
          prdy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (start) begin
      wr      = 1'b1;
      waddr   = '0;
      count_n = ONE;
      hi_n    = 1'b0;
      tok_n   = 1'b0;
      if (in_eop) begin
        state_n = S_IDLE;
        drops   = drops + 2'd1;
      end else begin
        state_n = S_RECV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      hi_ok     <= 1'b0;
      type_ok   <= 1'b0;
      rdy_q     <= 1'b0;
      addr_0    <= '0;
      data_0    <= '0;
      cs_0      <= 1'b0;
      we_0      <= 1'b0;
      pkt_ready <= 1'b0;
      pkt_len   <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      hi_ok     <= hi_n;
      type_ok   <= tok_n;
      rdy_q     <= 1'b1;
      cs_0      <= wr;
      we_0      <= wr;
      pkt_ready <= prdy_n;
      pkt_len   <= len_n;
      if (wr) begin
        addr_0 <= waddr;
        data_0 <= in_data;
      end
      drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ecpri_pkt_writer.sv
// Randomized bench for ecpri_pkt_writer with a frame-level
// reference model and RAM write monitor.
module tb_ecpri_pkt_writer;

  localparam int MAXL = 1500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_ready;
  logic [15:0] addr_0;
  logic [7:0]  data_0;
  logic        cs_0, we_0, oe_0;
  logic        pkt_ready;
  logic [15:0] pkt_len;
  logic        pkt_done = 1'b0;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  ecpri_pkt_writer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .addr_0   (addr_0),
    .data_0   (data_0),
    .cs_0     (cs_0),
    .we_0     (we_0),
    .oe_0     (oe_0),
    .pkt_ready(pkt_ready),
    .pkt_len  (pkt_len),
    .pkt_done (pkt_done),
    .drop_cnt (drop_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int exp_drops = 0;
  logic [7:0] mem [0:MAXL-1];
  logic [7:0] frm [$];
  int wr_count = 0;
  int max_addr = 0;

  always @(posedge clk) begin
    #1;
    if (reset && cs_0 && we_0) begin
      if (int'(addr_0) < MAXL) mem[addr_0] = data_0;
      wr_count++;
      if (int'(addr_0) > max_addr) max_addr = int'(addr_0);
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic beat(logic [7:0] d, bit s, bit e, int gap);
    int w;
    repeat (gap) idle();
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    in_sop = s;
    in_eop = e;
  endtask

  // tsel: 0 AEFE, 1 0800, 2 AE00, 3 00FE
  task automatic build(int len, int tsel);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    if (len > 13) begin
      case (tsel)
        0: begin frm[12] = 8'hAE; frm[13] = 8'hFE; end
        1: begin frm[12] = 8'h08; frm[13] = 8'h00; end
        2: begin frm[12] = 8'hAE; frm[13] = 8'h00; end
        default: begin frm[12] = 8'h00; frm[13] = 8'hFE; end
      endcase
    end
  endtask

  task automatic send(int n, int gap, bit rnd, bit with_eop);
    for (int i = 0; i < n; i++)
      beat(frm[i], i == 0, with_eop && i == n - 1,
           rnd ? int'($urandom_range(0, gap)) : gap);
  endtask

  task automatic expect_good(int len);
    int mism;
    int hold;
    idle();
    check("rdy_early", pkt_ready, 0);
    check("inrdy_hold", in_ready, 0);
    @(negedge clk);
    check("pkt_ready", pkt_ready, 1);
    check("pkt_len", pkt_len, len);
    check("drops", drop_cnt, exp_drops);
    mism = 0;
    for (int i = 0; i < len; i++) if (mem[i] !== frm[i]) mism++;
    check("ram", mism, 0);
    hold = $urandom_range(0, 4);
    repeat (hold) begin
      @(negedge clk);
      check("hold_inrdy", in_ready, 0);
      check("hold_len", pkt_len, len);
    end
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    check("done_clr", pkt_ready, 0);
    check("idle_rdy", in_ready, 1);
  endtask

  task automatic expect_drop();
    idle();
    @(negedge clk);
    check("no_pkt", pkt_ready, 0);
    check("drops", drop_cnt, exp_drops);
  endtask

  task automatic check_reset_vals();
    check("rst_inrdy", in_ready, 0);
    check("rst_addr", addr_0, 0);
    check("rst_data", data_0, 0);
    check("rst_cs", cs_0, 0);
    check("rst_we", we_0, 0);
    check("rst_oe", oe_0, 0);
    check("rst_prdy", pkt_ready, 0);
    check("rst_len", pkt_len, 0);
    check("rst_drop", drop_cnt, 0);
  endtask

  initial begin
    #300000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, kind, cut, gap;
    #2 reset = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", in_ready, 1);

    // good 64-byte frame
    build(64, 0); wr_count = 0;
    send(64, 0, 0, 1);
    expect_good(64);
    check("wr64", wr_count, 64);

    // wrong EtherType, still written
    build(64, 1); wr_count = 0;
    send(64, 0, 0, 1);
    exp_drops++;
    expect_drop();
    check("wr_bad", wr_count, 64);

    // short frame, then single-beat runt
    build(10, 0);
    send(10, 0, 0, 1);
    exp_drops++;
    expect_drop();
    beat(8'h55, 1, 1, 0);
    exp_drops++;
    expect_drop();

    // oversize frame
    build(1600, 0); wr_count = 0; max_addr = 0;
    send(1600, 0, 0, 1);
    exp_drops++;
    expect_drop();
    check("wr_over", wr_count, MAXL);
    check("max_addr", max_addr, MAXL - 1);
    build(60, 0);
    send(60, 0, 0, 1);
    expect_good(60);

    // length boundaries
    build(MAXL, 0);
    send(MAXL, 0, 0, 1);
    expect_good(MAXL);
    build(MAXL + 1, 0); wr_count = 0;
    send(MAXL + 1, 0, 0, 1);
    exp_drops++;
    expect_drop();
    check("wr_1501", wr_count, MAXL);
    build(18, 0);
    send(18, 0, 0, 1);
    expect_good(18);
    build(17, 0);
    send(17, 0, 0, 1);
    exp_drops++;
    expect_drop();

    // restart by sop mid-frame
    build(64, 0); wr_count = 0;
    send(30, 0, 0, 0);
    build(40, 0);
    send(40, 0, 0, 1);
    exp_drops++;
    expect_good(40);
    check("wr_cut", wr_count, 70);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      gap = $urandom_range(0, 2);
      case (kind)
        0: begin
          len = $urandom_range(18, 120);
          build(len, 0);
          send(len, gap, 1, 1);
          expect_good(len);
        end
        1: begin
          len = $urandom_range(18, 120);
          build(len, $urandom_range(1, 3));
          send(len, gap, 1, 1);
          exp_drops++;
          expect_drop();
        end
        2: begin
          len = $urandom_range(2, 17);
          build(len, 0);
          send(len, gap, 1, 1);
          exp_drops++;
          expect_drop();
        end
        3: begin
          beat(8'($urandom), 1, 1, gap);
          exp_drops++;
          expect_drop();
        end
        default: begin
          len = $urandom_range(14, 80);
          cut = $urandom_range(1, len - 1);
          build(len, 0);
          send(cut, gap, 1, 0);
          len = $urandom_range(18, 90);
          build(len, 0);
          send(len, gap, 1, 1);
          exp_drops++;
          expect_good(len);
        end
      endcase
    end

    // gapped 1-in-3 frame, then reset mid-frame
    build(20, 0);
    send(20, 2, 0, 1);
    expect_good(20);
    build(30, 0);
    send(10, 0, 0, 0);
    idle();
    #2 reset = 1'b0;
    #1 check_reset_vals();
    exp_drops = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rec_rdy", in_ready, 1);
    check("rec_drop", drop_cnt, 0);
    build(30, 0);
    send(30, 0, 0, 1);
    expect_good(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
